bcd_stopwatch_ctrl: RTL and testbench
=====================================

Name: bcd_stopwatch_ctrl

Overview:
- Sequencer for a chain of cascaded BCD digit up-counters forming a stopwatch display (digit 0 = least significant).
- Owns the run/pause/clear state machine, the tick prescaler, the per-digit increment enables and the display lap-freeze flag.
- Sits between the one-pulse button conditioners and the BCD digit counters.
- Counters feed back their "at 9" carry flags; the controller drives their increment enables and a synchronous clear.

Parameters:
- TICK_DIV, 100, clk cycles per count tick; range 2..2^24.
- DIGITS, 4, number of cascaded BCD digits; range 1..8.
- WRAP, 0, 0 = stop at all-9s (FULL state); 1 = roll over to all-0s and keep running.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start_pb  in  1  single-cycle pulse; start/pause toggle
- lap_pb  in  1  single-cycle pulse; toggles display freeze
- clr_pb  in  1  single-cycle pulse; clear to zero
- carry  in  DIGITS  carry[i]=1 when digit i holds 9
- inc_en  out  DIGITS  per-digit increment enable, one cycle
- digit_clr  out  1  synchronous clear to all digit counters, one cycle
- disp_freeze  out  1  1 = display latch holds the lap value
- tick  out  1  prescaler terminal pulse, qualified by RUN
- state  out  2  IDLE=00, RUN=01, PAUSE=10, FULL=11

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, prescaler=0, disp_freeze=0, digit_clr=0.
  - tick=0 and inc_en=0 (both combinational, qualified by state).
- Prescaler:
  - Counts 0..TICK_DIV-1, wraps to 0; advances only in RUN.
  - Holds its value in PAUSE, so resume keeps the partial period.
  - Forced to 0 in IDLE and FULL.
- tick = (state==RUN) & (prescaler==TICK_DIV-1).
- inc_en (combinational):
  - inc_en[0] = tick.
  - inc_en[i] = tick & carry[0] & ... & carry[i-1].
  - Digits update on the clk edge that samples tick; one-cycle latency from tick to the new count.
- all9 = &carry. Priority per cycle: clr_pb > FSM transition by start_pb > tick effects.
- FSM transitions:
  - IDLE: start_pb -> RUN.
  - RUN: start_pb -> PAUSE. A tick in the same cycle still issues inc_en.
  - RUN, WRAP=0: tick & all9 -> FULL. In that cycle inc_en is forced to all-0, so the digits hold 9..9.
  - RUN, WRAP=1: tick & all9 -> every inc_en asserted, the digits roll to 0..0, state stays RUN.
  - PAUSE: start_pb -> RUN.
  - FULL: start_pb and lap_pb ignored; only clr_pb exits.
  - Any state, clr_pb -> IDLE. digit_clr is registered high for exactly the next cycle, prescaler cleared, disp_freeze cleared.
- disp_freeze:
  - lap_pb toggles it in RUN or PAUSE; ignored in IDLE and FULL.
  - Cleared by clr_pb even if lap_pb arrives in the same cycle.
  - Retained across the FULL transition.
- The counters keep counting under disp_freeze; only the display latch holds.
- Reset mid-operation: immediate return to reset values. Digit counters clear through their own reset.
- Back-to-back pulses on consecutive cycles are each honoured (e.g. start, start -> RUN, then PAUSE).

Decomposition:
- Shared package (stopwatch_pkg):
  - State encoding constants ST_IDLE, ST_RUN, ST_PAUSE, ST_FULL.
  - BCD_MAX = 4'd9.
- One sub-module, tick_prescaler: parameter TICK_DIV; ports clk, rst, en, clr, tick.
- Carry-chain AND and FSM stay in the top.

Test Plan:
- TICK_DIV=4, DIGITS=2, reset, start_pb at cycle 5 -> state=RUN at cycle 6; tick every 4th cycle from cycle 9; inc_en=01 with carry=00.
- RUN with carry=01 at tick -> inc_en=11; carry=00 -> inc_en=01; mid-period no tick -> inc_en=00.
- RUN, prescaler=2, start_pb -> PAUSE with prescaler held at 2 for 10 cycles; start_pb -> RUN; next tick exactly 1 cycle later.
- WRAP=0, carry=11 at tick -> state=FULL, inc_en=00, start_pb ignored. Then clr_pb -> IDLE, digit_clr=1 for one cycle.
- WRAP=1, carry=11 at tick -> inc_en=11, state stays RUN.
- Simultaneous start_pb+clr_pb in RUN -> IDLE. lap_pb in RUN -> disp_freeze=1; lap_pb+clr_pb -> disp_freeze=0. rst low mid-RUN -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared encodings for the BCD stopwatch controller and its helpers.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_FULL  = 2'b11
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV enabled cycles.
// Holds its count while disabled; clr has priority over en.
module tick_prescaler #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Divider count: cleared, advanced while enabled, or held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en) begin
      cnt_r <= (cnt_r == LAST) ? {CW{1'b0}} : cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = en & (cnt_r == LAST);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/clear sequencer for a cascaded BCD stopwatch: drives per-digit
// increment enables from the prescaled tick and the counters' carry flags.
module bcd_stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 100,
  parameter int DIGITS   = 4,
  parameter bit WRAP     = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_pb,
  input  logic              lap_pb,
  input  logic              clr_pb,
  input  logic [DIGITS-1:0] carry,
  output logic [DIGITS-1:0] inc_en,
  output logic              digit_clr,
  output logic              disp_freeze,
  output logic              tick,
  output logic [1:0]        state
);

  state_t            state_r;
  state_t            state_nx;
  logic              tick_s;
  logic              all9_s;
  logic              stop_hit_s;
  logic              pre_clr_s;
  logic              kill_s;
  logic              chain_s;
  logic [DIGITS-1:0] inc_s;
  logic              freeze_r;
  logic              dclr_r;

  assign pre_clr_s  = clr_pb | (state_r == ST_IDLE) | (state_r == ST_FULL);
  assign all9_s     = &carry;
  // In stop mode a tick at 9..9 must not roll the digits over.
  assign stop_hit_s = tick_s & all9_s & ~WRAP;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (state_r == ST_RUN),
    .clr  (pre_clr_s),
    .tick (tick_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic: clear beats start, start beats the full-stop.
  always_comb begin
    state_nx = state_r;
    if (clr_pb) begin
      state_nx = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_nx = start_pb ? ST_RUN : ST_IDLE;
        ST_RUN: begin
          if (start_pb) begin
            state_nx = ST_PAUSE;
          end else if (stop_hit_s) begin
            state_nx = ST_FULL;
          end else begin
            state_nx = ST_RUN;
          end
        end
        ST_PAUSE: state_nx = start_pb ? ST_RUN : ST_PAUSE;
        ST_FULL:  state_nx = ST_FULL;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  // Output logic: ripple-carry enable chain across the digits.
  always_comb begin
    kill_s  = clr_pb | stop_hit_s;
    chain_s = 1'b1;
    inc_s   = {DIGITS{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      inc_s[i] = tick_s & chain_s & ~kill_s;
      chain_s  = chain_s & carry[i];
    end
  end

  // Registered digit clear and lap freeze flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dclr_r   <= 1'b0;
      freeze_r <= 1'b0;
    end else if (clr_pb) begin
      dclr_r   <= 1'b1;
      freeze_r <= 1'b0;
    end else begin
      dclr_r <= 1'b0;
      if (lap_pb && (state_r == ST_RUN || state_r == ST_PAUSE)) begin
        freeze_r <= ~freeze_r;
      end else begin
        freeze_r <= freeze_r;
      end
    end
  end

  assign inc_en      = inc_s;
  assign tick        = tick_s;
  assign state       = state_r;
  assign digit_clr   = dclr_r;
  assign disp_freeze = freeze_r;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for bcd_stopwatch_ctrl: a stop-mode and a wrap-mode instance
// share stimulus and are checked every cycle against a behavioural model.
module tb_bcd_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int ND = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_pb = 1'b0, lap_pb = 1'b0, clr_pb = 1'b0;
  logic [ND-1:0] carry = 2'b00;

  logic [ND-1:0] inc0, inc1;
  logic          dc0, dc1, fz0, fz1, tk0, tk1;
  logic [1:0]    st0, st1;

  int total = 0;
  int bad   = 0;

  // model: 0=IDLE 1=RUN 2=PAUSE 3=FULL
  int m_state [2];
  int m_pre   [2];
  int m_frz   [2];
  int m_dclr  [2];

  always #5 clk = ~clk;

  bcd_stopwatch_ctrl #(.TICK_DIV(TD), .DIGITS(ND), .WRAP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start_pb(start_pb), .lap_pb(lap_pb), .clr_pb(clr_pb),
    .carry(carry), .inc_en(inc0), .digit_clr(dc0), .disp_freeze(fz0),
    .tick(tk0), .state(st0));

  bcd_stopwatch_ctrl #(.TICK_DIV(TD), .DIGITS(ND), .WRAP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start_pb(start_pb), .lap_pb(lap_pb), .clr_pb(clr_pb),
    .carry(carry), .inc_en(inc1), .digit_clr(dc1), .disp_freeze(fz1),
    .tick(tk1), .state(st1));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_tick(input int k);
    return (m_state[k] == 1 && m_pre[k] == TD - 1) ? 1 : 0;
  endfunction

  // Digit i increments when the tick reaches it: every lower digit shows 9.
  function automatic int exp_inc(input int k);
    int len;
    int c;
    c = int'(carry);
    if (clr_pb || exp_tick(k) == 0) return 0;
    if (c == (1 << ND) - 1 && k == 0) return 0;
    len = 1;
    while (len < ND && ((c >> (len - 1)) & 1) == 1) len++;
    return (1 << len) - 1;
  endfunction

  // Behavioural model update on each clock edge (k = WRAP of the instance).
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_state[k] <= 0; m_pre[k] <= 0; m_frz[k] <= 0; m_dclr[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (clr_pb) begin
          m_state[k] <= 0; m_pre[k] <= 0; m_frz[k] <= 0; m_dclr[k] <= 1;
        end else begin
          m_dclr[k] <= 0;
          if (m_state[k] == 0 && start_pb) m_state[k] <= 1;
          else if (m_state[k] == 1 && start_pb) m_state[k] <= 2;
          else if (m_state[k] == 1 && exp_tick(k) == 1 && carry == 2'b11 && k == 0) m_state[k] <= 3;
          else if (m_state[k] == 2 && start_pb) m_state[k] <= 1;
          if (m_state[k] == 1) m_pre[k] <= (m_pre[k] + 1) % TD;
          else if (m_state[k] != 2) m_pre[k] <= 0;
          if (lap_pb && (m_state[k] == 1 || m_state[k] == 2)) m_frz[k] <= 1 - m_frz[k];
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("d0_state", int'(st0), m_state[0]);
    chk("d0_tick",  int'(tk0), exp_tick(0));
    chk("d0_inc",   int'(inc0), exp_inc(0));
    chk("d0_dclr",  int'(dc0), m_dclr[0]);
    chk("d0_frz",   int'(fz0), m_frz[0]);
    chk("d1_state", int'(st1), m_state[1]);
    chk("d1_tick",  int'(tk1), exp_tick(1));
    chk("d1_inc",   int'(inc1), exp_inc(1));
    chk("d1_dclr",  int'(dc1), m_dclr[1]);
    chk("d1_frz",   int'(fz1), m_frz[1]);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_pb = 1'b1; step(1); start_pb = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    #2 rst = 1'b0;
    step(2);
    chk("rst_state", int'(st0), 0);
    chk("rst_tick", int'(tk0), 0);
    chk("rst_inc", int'(inc0), 0);
    chk("rst_dclr", int'(dc0), 0);
    chk("rst_frz", int'(fz0), 0);
    rst = 1'b1;

    step(4);
    pulse_start();
    chk("run_entry", int'(st0), 1);
    chk("run_first_tick", int'(tk0), 0);
    step(3);
    chk("tick4_tick", int'(tk0), 1);
    chk("tick4_inc", int'(inc0), 1);

    carry = 2'b01;
    step(4);
    chk("carry01_inc", int'(inc0), 3);
    step(1);
    chk("midperiod_inc", int'(inc0), 0);
    carry = 2'b00;
    step(3);
    chk("carry00_inc", int'(inc0), 1);

    step(2);
    pulse_start();
    chk("pause_state", int'(st0), 2);
    step(10);
    chk("pause_hold", int'(st0), 2);
    pulse_start();
    chk("resume_state", int'(st0), 1);
    chk("resume_notick", int'(tk0), 0);
    step(1);
    chk("resume_tick", int'(tk0), 1);

    lap_pb = 1'b1; step(1); lap_pb = 1'b0;
    chk("lap_freeze", int'(fz0), 1);
    carry = 2'b11;
    step(3);
    chk("full_tick", int'(tk0), 1);
    chk("full_inc_stop", int'(inc0), 0);
    chk("full_inc_wrap", int'(inc1), 3);
    step(1);
    chk("full_state", int'(st0), 3);
    chk("wrap_state", int'(st1), 1);
    chk("full_frz_kept", int'(fz0), 1);
    start_pb = 1'b1; lap_pb = 1'b1; step(1); start_pb = 1'b0; lap_pb = 1'b0;
    chk("full_ignores_start", int'(st0), 3);
    chk("full_ignores_lap", int'(fz0), 1);
    clr_pb = 1'b1; step(1); clr_pb = 1'b0;
    chk("clr_state", int'(st0), 0);
    chk("clr_dclr", int'(dc0), 1);
    chk("clr_frz", int'(fz0), 0);
    step(1);
    chk("dclr_once", int'(dc0), 0);
    carry = 2'b00;

    pulse_start();
    lap_pb = 1'b1; step(1); lap_pb = 1'b0;
    start_pb = 1'b1; clr_pb = 1'b1; step(1); start_pb = 1'b0; clr_pb = 1'b0;
    chk("start_clr_state", int'(st0), 0);

    pulse_start();
    lap_pb = 1'b1; step(1); lap_pb = 1'b0;
    chk("lap_again", int'(fz0), 1);
    lap_pb = 1'b1; clr_pb = 1'b1; step(1); lap_pb = 1'b0; clr_pb = 1'b0;
    chk("lap_clr_frz", int'(fz0), 0);
    chk("lap_clr_state", int'(st0), 0);

    pulse_start();
    lap_pb = 1'b1; step(1); lap_pb = 1'b0;
    step(2);
    chk("pre_rst_tick", int'(tk0), 1);
    rst = 1'b0;
    #1;
    chk("arst_state", int'(st0), 0);
    chk("arst_tick", int'(tk0), 0);
    chk("arst_inc", int'(inc0), 0);
    chk("arst_frz", int'(fz0), 0);
    chk("arst_state1", int'(st1), 0);
    step(2);
    rst = 1'b1;
    step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
